// File: rtl/rf_operand_source.sv
// ---------------------------------------------------------------------------
// rf_operand_source
//
// Integer register file for the single-cycle RISC-V core. It holds 32 x 32-bit
// registers with x0 hardwired to zero. It drives both ALU operands and takes
// the write-back result (ALU result, load data or link address).
//
// Two combinational read ports and one synchronous write port. An optional
// write-through bypass lets a read see a write that is being presented in the
// same cycle.
//
// Parameters
//   BYPASS   : 1 forwards a same-cycle write to a matching read port,
//              0 returns the pre-write (stored) value until the edge.
//   SP_RESET : reset value of x2 (sp); every other register resets to 0.
//
// Ports
//   i_clk        : core clock, all state updates on the rising edge
//   i_rst        : asynchronous active-high reset
//   i_rs1_raddr  : operand 1 read address
//   o_rs1_rdata  : operand 1 data (ALU op1)
//   i_rs2_raddr  : operand 2 read address
//   o_rs2_rdata  : operand 2 data (ALU op2 / store data)
//   i_rd_wen     : write enable (RegWrite)
//   i_rd_waddr   : write-back destination register
//   i_rd_wdata   : write-back data
//   o_wr_count   : committed writes to x1..x31, wraps modulo 2^32
// ---------------------------------------------------------------------------
module rf_operand_source #(
  parameter bit          BYPASS   = 1'b1,
  parameter logic [31:0] SP_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1_raddr,
  output logic [31:0] o_rs1_rdata,
  input  logic [4:0]  i_rs2_raddr,
  output logic [31:0] o_rs2_rdata,
  input  logic        i_rd_wen,
  input  logic [4:0]  i_rd_waddr,
  input  logic [31:0] i_rd_wdata,
  output logic [31:0] o_wr_count
);

  // Only x1..x31 have storage; x0 is produced by the read muxes.
  logic [31:0] regs [1:31];
  logic [31:0] wr_count_q;
  logic        commit;
  logic        bypass_en;

  // A write to x0 is not a commit: it neither changes state nor counts.
  assign commit = i_rd_wen && (i_rd_waddr != 5'd0);

  // Forwarding is suppressed during reset so that the reads show the reset
  // contents rather than a write that will never commit.
  assign bypass_en = BYPASS && i_rd_wen && !i_rst;

  // Register array and commit counter. Both share the same commit condition,
  // so the count always matches the number of writes that actually landed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= (i == 2) ? SP_RESET : 32'h0;
      end
      wr_count_q <= 32'h0;
    end else if (commit) begin
      regs[i_rd_waddr] <= i_rd_wdata;
      wr_count_q       <= wr_count_q + 32'd1;
    end
  end

  assign o_wr_count = wr_count_q;

  // Read port 1. Address 0 wins over bypass, so x0 always reads zero.
  always_comb begin
    o_rs1_rdata = 32'h0;
    if (i_rs1_raddr != 5'd0) begin
      if (bypass_en && (i_rd_waddr == i_rs1_raddr)) begin
        o_rs1_rdata = i_rd_wdata;
      end else begin
        o_rs1_rdata = regs[i_rs1_raddr];
      end
    end
  end

  // Read port 2 resolves independently with the same rules as port 1.
  always_comb begin
    o_rs2_rdata = 32'h0;
    if (i_rs2_raddr != 5'd0) begin
      if (bypass_en && (i_rd_waddr == i_rs2_raddr)) begin
        o_rs2_rdata = i_rd_wdata;
      end else begin
        o_rs2_rdata = regs[i_rs2_raddr];
      end
    end
  end

endmodule
